// File: rtl/dispatch_buffer_pkg.sv
// Shared dispatch types: decoded-instruction entry, decode->core packet layout,
// buffer sizing and the buffer's run/halt state.
package dispatch_buffer_pkg;

   localparam int DISP_WIDTH  = 2;
   localparam int DISP_BUF_SZ = 8;
   localparam int DEQ_W       = $clog2(DISP_WIDTH + 1);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } disp_state_t;

   typedef struct packed {
      logic [4:0] dest_areg;
      logic [4:0] src1_areg;
      logic [4:0] src2_areg;
   } rat_entry_t;

   typedef struct packed {
      logic [31:0] pc;
   } rob_entry_t;

   typedef struct packed {
      logic [3:0]  fu_op;
      logic [15:0] imm;
   } rs_entry_t;

   typedef struct packed {
      rat_entry_t rat;
      rob_entry_t rob;
      rs_entry_t  rs;
      logic       halt;
   } dispatch_entry_t;

   typedef struct packed {
      logic [DISP_WIDTH-1:0]       valid;
      rat_entry_t [DISP_WIDTH-1:0] entries;
   } rat_is_input_t;

   // success marks a lane the ROB may treat as already complete (empty slot)
   typedef struct packed {
      logic       success;
      logic       halt;
      rob_entry_t entry;
   } rob_lane_t;

   typedef struct packed {
      logic [DISP_WIDTH-1:0]      valid;
      rob_lane_t [DISP_WIDTH-1:0] entries;
   } rob_is_packet_t;

   typedef struct packed {
      logic [DISP_WIDTH-1:0]      valid;
      rs_entry_t [DISP_WIDTH-1:0] entries;
   } id_rs_packet_t;

   typedef struct packed {
      rat_is_input_t  rat_is_input;
      rob_is_packet_t rob_is_packet;
      id_rs_packet_t  id_rs_packet;
   } id_ooo_packet_t;

endpackage

// File: rtl/dispatch_buffer_disp_pack.sv
// Maps the oldest buffered entries onto the decode->core packet lanes;
// lanes beyond the dispatch count are empty slots flagged as successful.
module disp_pack
   import dispatch_buffer_pkg::*;
(
   input  logic [DEQ_W-1:0]                 deq,
   input  dispatch_entry_t [DISP_WIDTH-1:0] head_entries,
   output id_ooo_packet_t                   packet
);

   always_comb begin
      packet = '0;
      for (int i = 0; i < DISP_WIDTH; i++) begin
         if (DEQ_W'(i) < deq) begin
            packet.rat_is_input.valid[i]             = 1'b1;
            packet.rat_is_input.entries[i]           = head_entries[i].rat;
            packet.rob_is_packet.valid[i]            = 1'b1;
            packet.rob_is_packet.entries[i].success  = 1'b0;
            packet.rob_is_packet.entries[i].halt     = head_entries[i].halt;
            packet.rob_is_packet.entries[i].entry    = head_entries[i].rob;
            packet.id_rs_packet.valid[i]             = 1'b1;
            packet.id_rs_packet.entries[i]           = head_entries[i].rs;
         end else begin
            packet.rob_is_packet.entries[i].success  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dispatch_buffer.sv
// Circular queue between decode and the out-of-order core: takes up to N
// instructions per cycle, dispatches up to N in order, flushes on squash.
//
// state  | meaning
// RUN    | accepting from decode and dispatching
// HALTED | WFI enqueued; draining only, no new entries until squash/reset
module dispatch_buffer
   import dispatch_buffer_pkg::*;
#(
   parameter  int DEPTH = DISP_BUF_SZ,
   localparam int N     = DISP_WIDTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  dispatch_entry_t [N-1:0] in_entries,
   input  logic [N-1:0]           in_valid,
   output logic                   in_ready,
   input  logic                   structural_hazard,
   input  logic                   squash,
   output id_ooo_packet_t         id_ooo_packet,
   output logic [CNT_W-1:0]       count_out,
   output logic                   halted_out
);

   localparam logic [CNT_W-1:0] ACCEPT_MAX = CNT_W'(DEPTH - N);
   localparam logic [CNT_W-1:0] N_CNT      = CNT_W'(N);

   dispatch_entry_t         mem [DEPTH];
   logic [PTR_W-1:0]        head;
   logic [PTR_W-1:0]        tail;
   logic [CNT_W-1:0]        count;
   disp_state_t             state;

   logic                    enq_fire;
   logic                    enq_halt;
   logic [DEQ_W-1:0]        enq_n;
   logic [DEQ_W-1:0]        enq_cnt;
   logic [DEQ_W-1:0]        deq;
   dispatch_entry_t [N-1:0] head_entries;

   // reset gates in_ready so decode sees "not ready" the moment reset asserts
   assign in_ready   = reset && (state == RUN) && !squash && (count <= ACCEPT_MAX);
   assign enq_fire   = in_ready && in_valid[0];
   assign enq_cnt    = enq_fire ? enq_n : '0;
   assign count_out  = count;
   assign halted_out = (state == HALTED);

   // lanes after a halt lane in the same beat are not taken
   always_comb begin
      enq_n    = '0;
      enq_halt = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (in_valid[i] && !enq_halt) begin
            enq_n    = enq_n + DEQ_W'(1);
            enq_halt = in_entries[i].halt;
         end
      end
   end

   always_comb begin
      deq = '0;
      if (!squash && !structural_hazard) begin
         deq = (count < N_CNT) ? DEQ_W'(count) : DEQ_W'(N);
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         head_entries[i] = mem[head + PTR_W'(i)];
      end
   end

   always_ff @(posedge clock) begin
      if (enq_fire) begin
         for (int i = 0; i < N; i++) begin
            if (DEQ_W'(i) < enq_n) begin
               mem[tail + PTR_W'(i)] <= in_entries[i];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= RUN;
      end else if (squash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= RUN;
      end else begin
         head  <= head + PTR_W'(deq);
         tail  <= tail + PTR_W'(enq_cnt);
         count <= count + CNT_W'(enq_cnt) - CNT_W'(deq);
         if (enq_fire && enq_halt) begin
            state <= HALTED;
         end
      end
   end

   disp_pack u_disp_pack (
      .deq          (deq),
      .head_entries (head_entries),
      .packet       (id_ooo_packet)
   );

`ifndef SYNTHESIS
   a_valid_prefix: assert property (@(posedge clock) disable iff (!reset)
      ((in_valid & (in_valid + N'(1))) == '0));
   a_count_max: assert property (@(posedge clock) disable iff (!reset)
      (count <= CNT_W'(DEPTH)));
   a_ptr_consistent: assert property (@(posedge clock) disable iff (!reset)
      (PTR_W'(tail - head) == PTR_W'(count)));
`endif

endmodule

// File: tb/tb_dispatch_buffer.sv
// Bench for dispatch_buffer: directed scenarios plus a random run, all
// checked against a queue-based model of the buffer.
module tb_dispatch_buffer;
   import dispatch_buffer_pkg::*;

   localparam int N     = DISP_WIDTH;
   localparam int DEPTH = DISP_BUF_SZ;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                    clock = 1'b0;
   logic                    reset = 1'b0;
   dispatch_entry_t [N-1:0] in_entries;
   logic [N-1:0]            in_valid = '0;
   logic                    in_ready;
   logic                    structural_hazard = 1'b0;
   logic                    squash = 1'b0;
   id_ooo_packet_t          id_ooo_packet;
   logic [CNT_W-1:0]        count_out;
   logic                    halted_out;

   dispatch_entry_t mq[$];
   bit              m_halted = 1'b0;
   int              n_checks = 0;
   int              n_pass   = 0;

   always #5 clock = ~clock;

   dispatch_buffer dut (
      .clock             (clock),
      .reset             (reset),
      .in_entries        (in_entries),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .structural_hazard (structural_hazard),
      .squash            (squash),
      .id_ooo_packet     (id_ooo_packet),
      .count_out         (count_out),
      .halted_out        (halted_out)
   );

   function automatic dispatch_entry_t rand_entry(input bit halt);
      dispatch_entry_t e;
      e.rat.dest_areg = 5'($urandom_range(0, 31));
      e.rat.src1_areg = 5'($urandom_range(0, 31));
      e.rat.src2_areg = 5'($urandom_range(0, 31));
      e.rob.pc        = $urandom;
      e.rs.fu_op      = 4'($urandom_range(0, 15));
      e.rs.imm        = 16'($urandom_range(0, 65535));
      e.halt          = halt;
      return e;
   endfunction

   task automatic drive(input logic [N-1:0] v, input bit haz, input bit sq, input bit h0, input bit h1);
      in_entries[0]     = rand_entry(h0);
      in_entries[1]     = rand_entry(h1);
      in_valid          = v;
      structural_hazard = haz;
      squash            = sq;
   endtask

   function automatic int m_deq();
      if (squash || structural_hazard) return 0;
      return (mq.size() < N) ? mq.size() : N;
   endfunction

   function automatic bit m_ready();
      return reset && !m_halted && !squash && (mq.size() <= DEPTH - N);
   endfunction

   // expected packet: oldest queued entries in order, empty lanes flagged success
   function automatic id_ooo_packet_t m_packet();
      id_ooo_packet_t p;
      int d;
      p = '0;
      d = m_deq();
      for (int i = 0; i < N; i++) begin
         if (i < d) begin
            p.rat_is_input.valid[i]            = 1'b1;
            p.rat_is_input.entries[i]          = mq[i].rat;
            p.rob_is_packet.valid[i]           = 1'b1;
            p.rob_is_packet.entries[i].halt    = mq[i].halt;
            p.rob_is_packet.entries[i].entry   = mq[i].rob;
            p.id_rs_packet.valid[i]            = 1'b1;
            p.id_rs_packet.entries[i]          = mq[i].rs;
         end else begin
            p.rob_is_packet.entries[i].success = 1'b1;
         end
      end
      return p;
   endfunction

   // apply the current inputs to the model, then advance one clock
   task automatic step();
      int d;
      bit r;
      d = m_deq();
      r = m_ready();
      if (squash) begin
         mq.delete();
         m_halted = 1'b0;
      end else begin
         repeat (d) void'(mq.pop_front());
         if (r && in_valid[0]) begin
            for (int i = 0; i < N; i++) begin
               if (!in_valid[i]) break;
               mq.push_back(in_entries[i]);
               if (in_entries[i].halt) begin
                  m_halted = 1'b1;
                  break;
               end
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      mq.delete();
      m_halted = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (count_out !== '0) $display("FAIL reset_count got=%0d exp=0", count_out);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready);
      else n_pass++;
      n_checks++;
      if (id_ooo_packet.rob_is_packet.valid !== '0 || id_ooo_packet.rat_is_input.valid !== '0 ||
          id_ooo_packet.id_rs_packet.valid !== '0)
         $display("FAIL reset_lanes got=%h exp=all lanes invalid", id_ooo_packet);
      else n_pass++;
      n_checks++;
      if (halted_out !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted_out);
      else n_pass++;
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", in_ready);
      else n_pass++;
      @(posedge clock);
      #1;
   endtask

   task automatic test_fill();
      logic [N-1:0] vecs [4] = '{2'b11, 2'b11, 2'b11, 2'b01};
      int           exp_c [4] = '{2, 4, 6, 7};
      int           exp_d [4] = '{5, 3, 1, 0};
      for (int k = 0; k < 4; k++) begin
         drive(vecs[k], 1'b1, 1'b0, 1'b0, 1'b0);
         @(negedge clock);
         n_checks++;
         if (in_ready !== 1'b1) $display("FAIL fill_ready k=%0d got=%b exp=1", k, in_ready);
         else n_pass++;
         n_checks++;
         if (id_ooo_packet !== m_packet()) $display("FAIL fill_packet k=%0d got=%h exp=%h", k, id_ooo_packet, m_packet());
         else n_pass++;
         step();
         n_checks++;
         if (count_out !== CNT_W'(exp_c[k])) $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count_out, exp_c[k]);
         else n_pass++;
      end
      drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL fill_full_ready got=%b exp=0", in_ready);
      else n_pass++;
      step();
      n_checks++;
      if (count_out !== CNT_W'(7)) $display("FAIL fill_dropped_count got=%0d exp=7", count_out);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clock);
         n_checks++;
         if (id_ooo_packet !== m_packet()) $display("FAIL fill_drain_packet k=%0d got=%h exp=%h", k, id_ooo_packet, m_packet());
         else n_pass++;
         step();
         n_checks++;
         if (count_out !== CNT_W'(exp_d[k])) $display("FAIL fill_drain_count k=%0d got=%0d exp=%0d", k, count_out, exp_d[k]);
         else n_pass++;
      end
   endtask

   task automatic test_drain_wrap();
      dispatch_entry_t first;
      int exp_c [2] = '{2, 0};
      apply_reset();
      repeat (3) begin
         drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      repeat (3) begin
         drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      for (int k = 0; k < 2; k++) begin
         drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
         if (k == 0) first = in_entries[0];
         step();
      end
      n_checks++;
      if (count_out !== CNT_W'(4)) $display("FAIL wrap_setup_count got=%0d exp=4", count_out);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clock);
         if (k == 0) begin
            n_checks++;
            if (id_ooo_packet.rob_is_packet.entries[0].entry !== first.rob)
               $display("FAIL wrap_first_pc got=%h exp=%h", id_ooo_packet.rob_is_packet.entries[0].entry, first.rob);
            else n_pass++;
         end
         n_checks++;
         if (id_ooo_packet !== m_packet()) $display("FAIL wrap_packet k=%0d got=%h exp=%h", k, id_ooo_packet, m_packet());
         else n_pass++;
         step();
         n_checks++;
         if (count_out !== CNT_W'(exp_c[k])) $display("FAIL wrap_count k=%0d got=%0d exp=%0d", k, count_out, exp_c[k]);
         else n_pass++;
      end
   endtask

   task automatic test_simultaneous();
      repeat (3) begin
         drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      for (int k = 0; k < 5; k++) begin
         drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clock);
         n_checks++;
         if (in_ready !== 1'b1) $display("FAIL simul_ready k=%0d got=%b exp=1", k, in_ready);
         else n_pass++;
         n_checks++;
         if (id_ooo_packet !== m_packet()) $display("FAIL simul_packet k=%0d got=%h exp=%h", k, id_ooo_packet, m_packet());
         else n_pass++;
         step();
         n_checks++;
         if (count_out !== CNT_W'(6)) $display("FAIL simul_count k=%0d got=%0d exp=6", k, count_out);
         else n_pass++;
      end
      repeat (3) begin
         drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clock);
         n_checks++;
         if (id_ooo_packet !== m_packet()) $display("FAIL simul_drain got=%h exp=%h", id_ooo_packet, m_packet());
         else n_pass++;
         step();
      end
   endtask

   task automatic test_squash();
      logic [N-1:0] vecs [3] = '{2'b11, 2'b11, 2'b01};
      for (int k = 0; k < 3; k++) begin
         drive(vecs[k], 1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      n_checks++;
      if (count_out !== CNT_W'(5)) $display("FAIL squash_setup_count got=%0d exp=5", count_out);
      else n_pass++;
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      n_checks++;
      if (id_ooo_packet.rob_is_packet.valid !== '0 || id_ooo_packet.rat_is_input.valid !== '0)
         $display("FAIL squash_lanes got=%h exp=all lanes invalid", id_ooo_packet);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL squash_ready got=%b exp=0", in_ready);
      else n_pass++;
      step();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      n_checks++;
      if (count_out !== '0) $display("FAIL squash_count got=%0d exp=0", count_out);
      else n_pass++;
      n_checks++;
      if (id_ooo_packet !== m_packet()) $display("FAIL squash_not_stored got=%h exp=%h", id_ooo_packet, m_packet());
      else n_pass++;
      step();
   endtask

   task automatic test_halt();
      drive(2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      n_checks++;
      if (count_out !== CNT_W'(1)) $display("FAIL halt_count got=%0d exp=1", count_out);
      else n_pass++;
      n_checks++;
      if (halted_out !== 1'b1) $display("FAIL halt_state got=%b exp=1", halted_out);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clock);
         n_checks++;
         if (in_ready !== 1'b0) $display("FAIL halt_ready k=%0d got=%b exp=0", k, in_ready);
         else n_pass++;
         n_checks++;
         if (id_ooo_packet !== m_packet()) $display("FAIL halt_packet k=%0d got=%h exp=%h", k, id_ooo_packet, m_packet());
         else n_pass++;
         step();
         n_checks++;
         if (count_out !== '0 || halted_out !== 1'b1)
            $display("FAIL halt_drain k=%0d got count=%0d halted=%b exp count=0 halted=1", k, count_out, halted_out);
         else n_pass++;
      end
      drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      n_checks++;
      if (halted_out !== 1'b0) $display("FAIL halt_exit_state got=%b exp=0", halted_out);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL halt_exit_ready got=%b exp=1", in_ready);
      else n_pass++;
      step();
   endtask

   task automatic test_async_reset();
      logic [N-1:0] vecs [3] = '{2'b11, 2'b11, 2'b01};
      for (int k = 0; k < 3; k++) begin
         drive(vecs[k], 1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (count_out !== '0) $display("FAIL async_reset_count got=%0d exp=0", count_out);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL async_reset_ready got=%b exp=0", in_ready);
      else n_pass++;
      n_checks++;
      if (id_ooo_packet.rob_is_packet.valid !== '0) $display("FAIL async_reset_lanes got=%b exp=00", id_ooo_packet.rob_is_packet.valid);
      else n_pass++;
      mq.delete();
      m_halted = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL async_release_ready got=%b exp=1", in_ready);
      else n_pass++;
      @(posedge clock);
      #1;
   endtask

   task automatic test_random();
      logic [N-1:0] v;
      for (int c = 0; c < 600; c++) begin
         case ($urandom_range(0, 2))
            0:       v = 2'b00;
            1:       v = 2'b01;
            default: v = 2'b11;
         endcase
         drive(v, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
         @(negedge clock);
         n_checks++;
         if (in_ready !== m_ready()) $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, m_ready());
         else n_pass++;
         n_checks++;
         if (id_ooo_packet !== m_packet()) $display("FAIL rand_packet c=%0d got=%h exp=%h", c, id_ooo_packet, m_packet());
         else n_pass++;
         n_checks++;
         if (count_out !== CNT_W'(mq.size())) $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count_out, mq.size());
         else n_pass++;
         n_checks++;
         if (halted_out !== m_halted) $display("FAIL rand_halted c=%0d got=%b exp=%b", c, halted_out, m_halted);
         else n_pass++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain_wrap();
      test_simultaneous();
      test_squash();
      test_halt();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dispatch_buffer.md
Name: dispatch_buffer

Overview:
- Decoupling FIFO between the decode stage and the out-of-order core; it is the producer of ID_OOO_PACKET.
- Accepts up to `N decoded instructions per cycle from decode.
- Holds them in a circular queue and presents up to `N in program order to the core whenever the core's structural_hazard is low.
- Flushes on squash; stops accepting after a halt (WFI) instruction until squash or reset.

Parameters:
- N, `N (2): dispatch/decode width in instructions per cycle.
- DEPTH, `DISP_BUF_SZ (8): queue entries; power of 2, DEPTH >= 2*N.
- PTR_W, $clog2(DEPTH): head/tail pointer width.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low; state clears while low.
- in_entries  in  N x DISPATCH_ENTRY  decoded instructions; lane 0 is oldest.
- in_valid  in  N  per-lane valid; must be a contiguous prefix (lane i valid implies lanes 0..i-1 valid).
- in_ready  out  1  buffer will take all valid lanes this cycle.
- structural_hazard  in  1  core cannot accept dispatch this cycle.
- squash  in  1  core misprediction flush.
- id_ooo_packet  out  ID_OOO_PACKET  up to N instructions to the core.
- count_out  out  CNT_W  current occupancy.
- halted_out  out  1  FSM is in HALTED.

Behaviour:
- **Reset** (reset low, asynchronous):
  - head = tail = 0, count = 0, state = RUN.
  - in_ready = 0, all id_ooo_packet lanes invalid, count_out = 0, halted_out = 0.
- **Storage:** DEPTH entries of DISPATCH_ENTRY in registers. head points to the oldest entry, tail to the next free slot. Both advance mod DEPTH, so wrap-around comes from natural PTR_W overflow.
- **in_ready** = (state == RUN) && !squash && (count <= DEPTH - N).
  - Based on current count only; same-cycle dequeues are not credited.
- **Enqueue** when in_ready && in_valid[0]:
  - Write lane i to slot tail+i for every valid lane.
  - tail += popcount(in_valid).
  - in_valid lanes with in_ready low are dropped; decode holds them.
- **Dequeue count** deq = (squash || structural_hazard) ? 0 : min(count, N).
- **Output lanes** (combinational from registered storage):
  - Lane i for i < deq carries entry head+i with every valid field set: rat_is_input, rob_is_packet.valid, id_rs_packet.valid.
  - Lanes i >= deq are all-zero except rob_is_packet.entries[i].success = TRUE.
  - head += deq.
  - Zero latency: an entry written at edge k is dispatchable in cycle k+1.
- **Counter:** count_next = count + enq - deq. It never exceeds DEPTH, guaranteed by the in_ready rule.
- **Squash** (sampled at the clock edge):
  - head = tail = 0, count = 0, state = RUN.
  - Enqueue and dequeue in that cycle are suppressed.
  - Squash takes priority over all other events.
- **FSM:**
  - RUN -> HALTED when an enqueued lane has entry.halt set. Lanes after the halt lane in the same beat are discarded; tail advances only through the halt lane.
  - HALTED: in_ready = 0; dequeue continues until empty. The buffer stays HALTED when empty.
  - HALTED -> RUN on squash only; reset also returns to RUN.
- **Simultaneous enqueue and dequeue** on a full-minus-N queue is legal; the pointers stay consistent.
- **Assertions** (simulation only):
  - in_valid is a contiguous prefix.
  - count <= DEPTH.
  - (tail - head) mod DEPTH == count mod DEPTH.

Decomposition:
- Shared sys_defs package:
  - DISPATCH_ENTRY typedef: per-instruction rat/rob/rs fields plus a halt bit.
  - `DISP_BUF_SZ constant.
  - DISP_STATE enum {RUN, HALTED}.
- The existing ID_OOO_PACKET typedef is reused unchanged.
- One natural sub-module: disp_pack, a combinational unit that maps head entries plus deq into the ID_OOO_PACKET lane layout. Pointer, counter and FSM logic stay in dispatch_buffer.

Test Plan:
- Reset low mid-traffic with count=5 -> count_out=0, in_ready=0, all lanes invalid immediately (asynchronous); after release, in_ready=1 on the first cycle.
- Fill: in_valid=2'b11 for 3 cycles with structural_hazard=1 -> count_out goes 2,4,6; in_ready drops to 0 once count=7 is reached via in_valid=2'b01; count=7 > 8-2.
- Drain with wrap: head=6, count=4, structural_hazard=0, no input -> lanes carry slots 6,7 then 0,1; count 4->2->0; final head=2.
- Simultaneous: count=6, enqueue 2, dequeue 2 -> count stays 6; program order is preserved across the wrap.
- Squash with count=5 and in_valid=2'b11 -> no lane valid that cycle; next cycle count=0, head=tail=0, and the inputs were not stored.
- Halt: enqueue {lane0 halt=1, lane1 valid} -> only lane0 stored; halted_out=1, in_ready=0; the queue drains to 0 and stays HALTED; squash -> halted_out=0, in_ready=1.
